// File: rtl/cpu.sv
// Three-phase (fetch/decode/execute) register-register processor with an
// internal 16x16 instruction ROM and a 16x8 register RAM.

module cpu_rom (
  input  logic        i_clk,
  input  logic        i_we,
  input  logic [3:0]  i_waddr,
  input  logic [15:0] i_wdata,
  input  logic [3:0]  i_raddr,
  output logic [15:0] o_rdata
);
  logic [15:0] mem [0:15];

  // Load port exists for in-system programming; the core ties it off.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];
endmodule

module cpu_ram (
  input  logic       i_clk,
  input  logic       i_we,
  input  logic [3:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [3:0] i_raddr1,
  input  logic [3:0] i_raddr2,
  output logic [7:0] o_rdata1,
  output logic [7:0] o_rdata2
);
  logic [7:0] mem [0:15];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata1 = mem[i_raddr1];
  assign o_rdata2 = mem[i_raddr2];
endmodule

module cpu (
  input  logic clk,
  input  logic rst
);
  typedef enum logic [2:0] {
    PH_FETCH  = 3'b001,
    PH_DECODE = 3'b010,
    PH_EXEC   = 3'b100
  } phase_t;

  phase_t      r_phase;
  logic [3:0]  pc;
  logic [15:0] raw_instruction;
  logic [3:0]  op_code;
  logic [3:0]  dest_reg;
  logic [3:0]  source_reg_one;
  logic [3:0]  source_reg_two;
  logic [7:0]  ram_out_data_1;
  logic [7:0]  ram_out_data_2;
  logic [7:0]  ram_in_data_1;
  logic        fetch_clk;
  logic        dec_clk;
  logic        alu_clk;

  logic [15:0] w_rom_data;
  logic [7:0]  w_rd1;
  logic [7:0]  w_rd2;
  logic [7:0]  w_alu_res;
  logic        w_op_valid;
  logic        w_ram_we;

  function automatic logic [7:0] alu(input logic [3:0] op,
                                     input logic [7:0] a,
                                     input logic [7:0] b);
    logic [15:0] prod;
    logic [15:0] rot;
    prod = {8'd0, a} * {8'd0, b};
    rot  = {a, a} >> b[2:0];
    case (op)
      4'd0:    alu = a + b;
      4'd1:    alu = a - b;
      4'd2:    alu = prod[7:0];
      4'd3:    alu = a | b;
      4'd4:    alu = a & b;
      4'd5:    alu = a ^ b;
      4'd6:    alu = (b >= 8'd8) ? 8'd0 : (a >> b[2:0]);
      4'd7:    alu = (b >= 8'd8) ? 8'd0 : (a << b[2:0]);
      4'd8:    alu = rot[7:0];
      default: alu = 8'd0;
    endcase
  endfunction

  function automatic logic op_is_valid(input logic [3:0] op);
    op_is_valid = (op <= 4'd8);
  endfunction

  assign fetch_clk  = (r_phase == PH_FETCH);
  assign dec_clk    = (r_phase == PH_DECODE);
  assign alu_clk    = (r_phase == PH_EXEC);
  assign w_alu_res  = alu(op_code, ram_out_data_1, ram_out_data_2);
  assign w_op_valid = op_is_valid(op_code);
  // Gated by rst so an instruction aborted by reset never commits.
  assign w_ram_we   = alu_clk & ~rst & w_op_valid;

  cpu_rom ROM_i (
    .i_clk   (clk),
    .i_we    (1'b0),
    .i_waddr (4'd0),
    .i_wdata (16'd0),
    .i_raddr (pc),
    .o_rdata (w_rom_data)
  );

  cpu_ram RAM_i (
    .i_clk    (clk),
    .i_we     (w_ram_we),
    .i_waddr  (dest_reg),
    .i_wdata  (w_alu_res),
    .i_raddr1 (raw_instruction[7:4]),
    .i_raddr2 (raw_instruction[3:0]),
    .o_rdata1 (w_rd1),
    .o_rdata2 (w_rd2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase         <= PH_FETCH;
      pc              <= 4'd0;
      raw_instruction <= 16'd0;
      op_code         <= 4'd0;
      dest_reg        <= 4'd0;
      source_reg_one  <= 4'd0;
      source_reg_two  <= 4'd0;
      ram_out_data_1  <= 8'd0;
      ram_out_data_2  <= 8'd0;
      ram_in_data_1   <= 8'd0;
    end else begin
      case (r_phase)
        // fetch -> decode
        PH_FETCH: begin
          raw_instruction <= w_rom_data;
          pc              <= pc + 4'd1;
          r_phase         <= PH_DECODE;
        end
        // decode -> execute
        PH_DECODE: begin
          op_code        <= raw_instruction[15:12];
          dest_reg       <= raw_instruction[11:8];
          source_reg_one <= raw_instruction[7:4];
          source_reg_two <= raw_instruction[3:0];
          ram_out_data_1 <= w_rd1;
          ram_out_data_2 <= w_rd2;
          r_phase        <= PH_EXEC;
        end
        // execute -> fetch
        PH_EXEC: begin
          if (w_op_valid) ram_in_data_1 <= w_alu_res;
          r_phase <= PH_FETCH;
        end
        default: r_phase <= PH_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu.sv
// Directed self-checking bench for cpu: memories are preloaded hierarchically
// and results are read back from RAM and the datapath registers.

module tb_cpu;
  logic clk;
  logic rst;
  int   passed;
  int   total;

  cpu dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset and fill memories: ROM with no-ops, RAM with zeros.
  task automatic hold_and_clear();
    rst = 1'b1;
    run(2);
    for (int i = 0; i < 16; i++) begin
      dut.ROM_i.mem[i] = 16'hF000;
      dut.RAM_i.mem[i] = 8'h00;
    end
  endtask

  task automatic test_reset();
    hold_and_clear();
    dut.ROM_i.mem[0] = 16'h0312;
    dut.ROM_i.mem[1] = 16'h0412;
    dut.RAM_i.mem[1] = 8'd5;
    dut.RAM_i.mem[2] = 8'd3;
    dut.RAM_i.mem[0] = 8'h5A;
    rst = 1'b0;
    run(5);
    rst = 1'b1;
    run(2);
    total++; if (dut.pc !== 4'd0) $display("FAIL rst_pc got %0d want 0", dut.pc); else passed++;
    total++; if ({dut.fetch_clk, dut.dec_clk, dut.alu_clk} !== 3'b100)
      $display("FAIL rst_phase got %b want 100", {dut.fetch_clk, dut.dec_clk, dut.alu_clk}); else passed++;
    total++; if (dut.raw_instruction !== 16'd0) $display("FAIL rst_raw got %h want 0000", dut.raw_instruction); else passed++;
    total++; if ({dut.op_code, dut.dest_reg, dut.source_reg_one, dut.source_reg_two} !== 16'd0)
      $display("FAIL rst_fields got %h want 0000", {dut.op_code, dut.dest_reg, dut.source_reg_one, dut.source_reg_two}); else passed++;
    total++; if ({dut.ram_out_data_1, dut.ram_out_data_2, dut.ram_in_data_1} !== 24'd0)
      $display("FAIL rst_data got %h want 000000", {dut.ram_out_data_1, dut.ram_out_data_2, dut.ram_in_data_1}); else passed++;
    total++; if (dut.RAM_i.mem[0] !== 8'h5A) $display("FAIL rst_ram0 got %h want 5a", dut.RAM_i.mem[0]); else passed++;
    total++; if (dut.RAM_i.mem[3] !== 8'd8) $display("FAIL rst_ram3 got %h want 08", dut.RAM_i.mem[3]); else passed++;
    total++; if (dut.RAM_i.mem[4] !== 8'd0) $display("FAIL rst_ram4 got %h want 00", dut.RAM_i.mem[4]); else passed++;
  endtask

  task automatic test_add();
    hold_and_clear();
    dut.ROM_i.mem[0] = 16'h0312;
    dut.RAM_i.mem[1] = 8'd5;
    dut.RAM_i.mem[2] = 8'd3;
    rst = 1'b0;
    run(1);
    total++; if (dut.dec_clk !== 1'b1 || dut.pc !== 4'd1 || dut.raw_instruction !== 16'h0312)
      $display("FAIL add_fetch got dec=%b pc=%0d raw=%h want 1 1 0312", dut.dec_clk, dut.pc, dut.raw_instruction); else passed++;
    run(2);
    total++; if (dut.RAM_i.mem[3] !== 8'd8) $display("FAIL add_ram got %h want 08", dut.RAM_i.mem[3]); else passed++;
    total++; if (dut.ram_in_data_1 !== 8'd8) $display("FAIL add_in got %h want 08", dut.ram_in_data_1); else passed++;
    total++; if (dut.pc !== 4'd1 || dut.fetch_clk !== 1'b1)
      $display("FAIL add_pc got pc=%0d fetch=%b want 1 1", dut.pc, dut.fetch_clk); else passed++;
  endtask

  task automatic test_sub_mul();
    hold_and_clear();
    dut.ROM_i.mem[0] = 16'h1412;
    dut.ROM_i.mem[1] = 16'h2956;
    dut.RAM_i.mem[1] = 8'd3;
    dut.RAM_i.mem[2] = 8'd5;
    dut.RAM_i.mem[5] = 8'd16;
    dut.RAM_i.mem[6] = 8'd32;
    dut.RAM_i.mem[9] = 8'h77;
    rst = 1'b0;
    run(3);
    total++; if (dut.RAM_i.mem[4] !== 8'hFE) $display("FAIL sub_wrap got %h want fe", dut.RAM_i.mem[4]); else passed++;
    run(3);
    total++; if (dut.RAM_i.mem[9] !== 8'h00) $display("FAIL mul_trunc got %h want 00", dut.RAM_i.mem[9]); else passed++;
    total++; if (dut.ram_in_data_1 !== 8'h00) $display("FAIL mul_in got %h want 00", dut.ram_in_data_1); else passed++;
  endtask

  task automatic test_logic_shift();
    logic [7:0] exp [0:8];
    logic [3:0] dst [0:8];
    hold_and_clear();
    dut.RAM_i.mem[1] = 8'hB4;
    dut.RAM_i.mem[2] = 8'd2;
    dut.RAM_i.mem[3] = 8'h81;
    dut.RAM_i.mem[4] = 8'd9;
    dut.RAM_i.mem[6] = 8'd8;
    dut.RAM_i.mem[7] = 8'h55;
    dut.RAM_i.mem[8] = 8'hAA;
    dut.ROM_i.mem[0] = 16'h3A12; dst[0] = 4'hA; exp[0] = 8'hB6;
    dut.ROM_i.mem[1] = 16'h4B12; dst[1] = 4'hB; exp[1] = 8'h00;
    dut.ROM_i.mem[2] = 16'h5C12; dst[2] = 4'hC; exp[2] = 8'hB6;
    dut.ROM_i.mem[3] = 16'h6D12; dst[3] = 4'hD; exp[3] = 8'h2D;
    dut.ROM_i.mem[4] = 16'h7E12; dst[4] = 4'hE; exp[4] = 8'hD0;
    dut.ROM_i.mem[5] = 16'h8F12; dst[5] = 4'hF; exp[5] = 8'h2D;
    dut.ROM_i.mem[6] = 16'h8534; dst[6] = 4'h5; exp[6] = 8'hC0;
    dut.ROM_i.mem[7] = 16'h6716; dst[7] = 4'h7; exp[7] = 8'h00;
    dut.ROM_i.mem[8] = 16'h7816; dst[8] = 4'h8; exp[8] = 8'h00;
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run(3);
      total++;
      if (dut.RAM_i.mem[dst[i]] !== exp[i])
        $display("FAIL alu_op%0d got %h want %h", i, dut.RAM_i.mem[dst[i]], exp[i]);
      else passed++;
    end
  endtask

  task automatic test_chain_nop();
    hold_and_clear();
    dut.ROM_i.mem[0] = 16'h0312;
    dut.ROM_i.mem[1] = 16'h0533;
    dut.ROM_i.mem[2] = 16'hF712;
    dut.RAM_i.mem[1] = 8'd5;
    dut.RAM_i.mem[2] = 8'd3;
    dut.RAM_i.mem[7] = 8'hAB;
    rst = 1'b0;
    run(6);
    total++; if (dut.RAM_i.mem[5] !== 8'd16) $display("FAIL chain got %h want 10", dut.RAM_i.mem[5]); else passed++;
    run(3);
    total++; if (dut.RAM_i.mem[7] !== 8'hAB) $display("FAIL nop_ram got %h want ab", dut.RAM_i.mem[7]); else passed++;
    total++; if (dut.ram_in_data_1 !== 8'd16) $display("FAIL nop_hold got %h want 10", dut.ram_in_data_1); else passed++;
  endtask

  task automatic test_wrap();
    hold_and_clear();
    dut.ROM_i.mem[0] = 16'h0110;
    dut.RAM_i.mem[0] = 8'd1;
    rst = 1'b0;
    run(48);
    total++; if (dut.pc !== 4'd0 || dut.fetch_clk !== 1'b1)
      $display("FAIL wrap_pc got pc=%0d fetch=%b want 0 1", dut.pc, dut.fetch_clk); else passed++;
    total++; if (dut.RAM_i.mem[1] !== 8'd1) $display("FAIL wrap_once got %h want 01", dut.RAM_i.mem[1]); else passed++;
    run(3);
    total++; if (dut.RAM_i.mem[1] !== 8'd2 || dut.pc !== 4'd1)
      $display("FAIL wrap_again got r1=%h pc=%0d want 02 1", dut.RAM_i.mem[1], dut.pc); else passed++;
  endtask

  task automatic test_reset_abort();
    hold_and_clear();
    dut.ROM_i.mem[0] = 16'h0312;
    dut.RAM_i.mem[1] = 8'd5;
    dut.RAM_i.mem[2] = 8'd3;
    dut.RAM_i.mem[3] = 8'h99;
    rst = 1'b0;
    run(1);
    rst = 1'b1;
    run(1);
    total++; if (dut.pc !== 4'd0 || dut.fetch_clk !== 1'b1 || dut.raw_instruction !== 16'd0)
      $display("FAIL abort_dec got pc=%0d fetch=%b raw=%h want 0 1 0000", dut.pc, dut.fetch_clk, dut.raw_instruction); else passed++;
    total++; if (dut.RAM_i.mem[3] !== 8'h99) $display("FAIL abort_dec_ram got %h want 99", dut.RAM_i.mem[3]); else passed++;
    rst = 1'b0;
    run(2);
    total++; if (dut.alu_clk !== 1'b1) $display("FAIL abort_phase got alu=%b want 1", dut.alu_clk); else passed++;
    rst = 1'b1;
    run(1);
    total++; if (dut.RAM_i.mem[3] !== 8'h99) $display("FAIL abort_exe_ram got %h want 99", dut.RAM_i.mem[3]); else passed++;
    rst = 1'b0;
    run(3);
    total++; if (dut.RAM_i.mem[3] !== 8'd8 || dut.pc !== 4'd1)
      $display("FAIL restart got r3=%h pc=%0d want 08 1", dut.RAM_i.mem[3], dut.pc); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    test_reset();
    test_add();
    test_sub_mul();
    test_logic_shift();
    test_chain_nop();
    test_wrap();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cpu.md
# cpu

Three-phase, multi-cycle accumulator-free register-register processor used as the top-level compute block. A 16-entry instruction ROM feeds a fetch → decode → execute sequencer; operands come from a 16-entry register RAM; a 9-operation ALU writes the result back to the RAM. No external data ports: program and data are preloaded into the internal memories by the bench, and results are observed hierarchically.

## Interface
- No parameters. Data width fixed at 8 bits, instruction width 16 bits, 16 ROM words, 16 RAM words.
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- Required internal hierarchy (bench-visible): ROM_i.mem[0:15] (16-bit words), RAM_i.mem[0:15] (8-bit words), pc (4-bit), raw_instruction (16), op_code (4), dest_reg, source_reg_one, source_reg_two (4 each), ram_out_data_1, ram_out_data_2, ram_in_data_1 (8 each), fetch_clk, dec_clk, alu_clk (1 each, one-hot phase flags).

## Operation
- Instruction format: [15:12] op_code, [11:8] dest_reg, [7:4] source_reg_one, [3:0] source_reg_two.
- Phases, one clock each, one-hot in fetch_clk/dec_clk/alu_clk:
  - FETCH: raw_instruction <= ROM_i.mem[pc]; pc <= pc+1 (4-bit, wraps 15 → 0).
  - DECODE: latch op_code and register fields from raw_instruction; ram_out_data_1 <= RAM[source_reg_one], ram_out_data_2 <= RAM[source_reg_two].
  - EXECUTE: ram_in_data_1 <= ALU(op_code, A=ram_out_data_1, B=ram_out_data_2); RAM[dest_reg] written with the same result on this edge. Next phase FETCH.
- ALU (all results truncated to 8 bits):
  - 0000 ADD A+B; 0001 SUB A−B (two's-complement wrap); 0010 MUL low 8 bits of A*B; 0011 OR; 0100 AND; 0101 XOR.
  - 0110 SHR A>>B logical; 0111 SHL A<<B; B≥8 gives 0 for both.
  - 1000 ROR A rotated right by B mod 8.
  - 1001–1111: no operation; RAM not written; ram_in_data_1 holds previous value.
- dest_reg equal to a source register is legal: sources were read in DECODE, so the old value is used.
- RAM and ROM contents are not modified by reset (preloaded data must survive).

## Timing
- Reset (rst high at a rising edge): pc=0, phase=FETCH (fetch_clk=1, dec_clk=0, alu_clk=0), raw_instruction=0, op_code/dest/source fields=0, ram_out_data_1/2=0, ram_in_data_1=0. Held while rst high.
- Operation starts on first rising edge with rst low; that edge performs FETCH of ROM[0].
- Each instruction: exactly 3 cycles; result visible in RAM on the EXECUTE edge, available to the next instruction's DECODE (no hazards).
- Reset asserted mid-instruction aborts it; a partially executed instruction never writes RAM after reset.
- Program runs continuously; after ROM[15] execution continues at ROM[0].

## Test plan
- Reset: hold rst 2 cycles → pc=0, fetch_clk=1, all datapath regs 0, RAM preload unchanged.
- ADD: RAM[1]=5, RAM[2]=3, ROM[0]=16'h0312 → after 3 cycles RAM[3]=8, ram_in_data_1=8, pc=1.
- SUB wrap and MUL truncation: RAM[1]=3, RAM[2]=5, ROM[0]=16'h1412 → RAM[4]=8'hFE; RAM[1]=16, RAM[2]=32, op 0010 → 0.
- Logic/shift: A=8'hB4, B=2 → OR B6, AND 00, XOR B6, SHR 2D, SHL D0, ROR 2D; A=8'h81, B=9, ROR → C0; SHR with B=8 → 0.
- Dependency chain: ROM[0]=0312, ROM[1]=0533 (R5=R3+R3) → R5=16 after 6 cycles; undefined opcode 16'hF712 leaves R7 unchanged.
- Wrap: 16 instructions run (48 cycles) → pc returns to 0 and ROM[0] executes again; reset asserted during DECODE → no RAM write, restart at ROM[0].
